// File: rtl/bsg_idiv_arb_if.sv
// rtl/bsg_idiv_arb_if.sv - client and divider handshake bundle for bsg_idiv_arb
//
// Purpose: carries every request/response/divider signal of bsg_idiv_arb.
// Signal names keep the arbiter's point of view (_i = into the arbiter).
//   client side : v_i, dividend_i, divisor_i, signed_div_i -> ready_and_o
//                 v_o, quotient_o, remainder_o            <- yumi_i
//   divider side: div_v_o, div_dividend_o, div_divisor_o, div_signed_o <- div_ready_and_i
//                 div_v_i, div_quotient_i, div_remainder_i -> div_yumi_o
// Modports: master = the arbiter, slave = clients plus divider.
interface bsg_idiv_arb_if #(
  parameter int els_p   = 4,
  parameter int width_p = 32
);
  logic [els_p-1:0]         v_i;
  logic [els_p*width_p-1:0] dividend_i;
  logic [els_p*width_p-1:0] divisor_i;
  logic [els_p-1:0]         signed_div_i;
  logic [els_p-1:0]         ready_and_o;
  logic [els_p-1:0]         v_o;
  logic [width_p-1:0]       quotient_o;
  logic [width_p-1:0]       remainder_o;
  logic [els_p-1:0]         yumi_i;

  logic                     div_v_o;
  logic [width_p-1:0]       div_dividend_o;
  logic [width_p-1:0]       div_divisor_o;
  logic                     div_signed_o;
  logic                     div_ready_and_i;
  logic                     div_v_i;
  logic [width_p-1:0]       div_quotient_i;
  logic [width_p-1:0]       div_remainder_i;
  logic                     div_yumi_o;

  modport master (
    input  v_i, dividend_i, divisor_i, signed_div_i, yumi_i,
           div_ready_and_i, div_v_i, div_quotient_i, div_remainder_i,
    output ready_and_o, v_o, quotient_o, remainder_o,
           div_v_o, div_dividend_o, div_divisor_o, div_signed_o, div_yumi_o
  );

  modport slave (
    output v_i, dividend_i, divisor_i, signed_div_i, yumi_i,
           div_ready_and_i, div_v_i, div_quotient_i, div_remainder_i,
    input  ready_and_o, v_o, quotient_o, remainder_o,
           div_v_o, div_dividend_o, div_divisor_o, div_signed_o, div_yumi_o
  );
endinterface

// File: rtl/bsg_idiv_arb.sv
// rtl/bsg_idiv_arb.sv - round-robin sharing of one iterative divider among els_p clients
//
// Purpose: grants one client at a time (round-robin from rr_ptr), registers its
// operands, issues them to the divider, latches the result and returns it to
// the owning client only.
// Ports:
//   clk_i          clock, posedge
//   reset_n_i      asynchronous active-low reset (shared with the divider)
//   bus            bsg_idiv_arb_if.master, client and divider handshakes
//   busy_cycles_o  (BSG_IDIV_ARB_PERF_EN only) saturating count of non-idle cycles
//   ops_done_o     (BSG_IDIV_ARB_PERF_EN only) saturating count of consumed results
// Optional feature macro: BSG_IDIV_ARB_PERF_EN
module bsg_idiv_arb #(
  parameter int els_p   = 4,
  parameter int width_p = 32
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
`ifdef BSG_IDIV_ARB_PERF_EN
  output logic [31:0] busy_cycles_o,
  output logic [31:0] ops_done_o,
`endif
  bsg_idiv_arb_if.master bus
);
  localparam int lg_els_lp = $clog2(els_p);
  // one extra bit so rr_ptr + offset never overflows before the wrap
  localparam int cand_w_lp = lg_els_lp + 1;

  typedef enum logic [1:0] {eIdle, eIssue, eWait, eResp} state_e;

  state_e                 state;
  logic [lg_els_lp-1:0]   rr_ptr;
  logic [lg_els_lp-1:0]   tag;
  logic [width_p-1:0]     dividend;
  logic [width_p-1:0]     divisor;
  logic                   signed_sel;
  logic [width_p-1:0]     quotient;
  logic [width_p-1:0]     remainder;
  logic                   div_v;
  logic [els_p-1:0]       v_res;

  logic                   grant_found;
  logic [lg_els_lp-1:0]   grant_idx;
  logic [cand_w_lp-1:0]   cand;
  logic [els_p-1:0]       grant;

  // First requester at or after rr_ptr, wrapping modulo els_p (works for
  // non-power-of-two els_p because the wrap is an explicit subtract).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < els_p; i++) begin
      cand = cand_w_lp'(rr_ptr) + cand_w_lp'(i);
      if (cand >= cand_w_lp'(els_p)) cand = cand - cand_w_lp'(els_p);
      if (!grant_found && bus.v_i[cand[lg_els_lp-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[lg_els_lp-1:0];
      end
    end
  end

  // Grant is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    grant = '0;
    if (reset_n_i && (state == eIdle) && grant_found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= eIdle;
      rr_ptr     <= '0;
      tag        <= '0;
      dividend   <= '0;
      divisor    <= '0;
      signed_sel <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      div_v      <= 1'b0;
      v_res      <= '0;
    end else begin
      unique case (state)
        eIdle: begin
          if (grant_found) begin
            dividend   <= bus.dividend_i[grant_idx*width_p +: width_p];
            divisor    <= bus.divisor_i[grant_idx*width_p +: width_p];
            signed_sel <= bus.signed_div_i[grant_idx];
            tag        <= grant_idx;
            div_v      <= 1'b1;
            state      <= eIssue;
          end
        end
        eIssue: begin
          if (bus.div_ready_and_i) begin
            div_v <= 1'b0;
            state <= eWait;
          end
        end
        eWait: begin
          if (bus.div_v_i) begin
            quotient  <= bus.div_quotient_i;
            remainder <= bus.div_remainder_i;
            v_res     <= {{(els_p-1){1'b0}}, 1'b1} << tag;
            state     <= eResp;
          end
        end
        eResp: begin
          // only the owner's consume matters; other yumi bits are ignored
          if (bus.yumi_i[tag]) begin
            v_res  <= '0;
            rr_ptr <= (tag == lg_els_lp'(els_p - 1)) ? '0 : tag + 1'b1;
            state  <= eIdle;
          end
        end
        default: state <= eIdle;
      endcase
    end
  end

  assign bus.ready_and_o    = grant;
  assign bus.v_o            = v_res;
  assign bus.quotient_o     = quotient;
  assign bus.remainder_o    = remainder;
  assign bus.div_v_o        = div_v;
  assign bus.div_dividend_o = dividend;
  assign bus.div_divisor_o  = divisor;
  assign bus.div_signed_o   = signed_sel;
  assign bus.div_yumi_o     = (state == eWait) & bus.div_v_i;

`ifdef BSG_IDIV_ARB_PERF_EN
  logic [31:0] busy_cnt;
  logic [31:0] ops_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_cnt <= '0;
      ops_cnt  <= '0;
    end else begin
      if ((state != eIdle) && (busy_cnt != '1)) busy_cnt <= busy_cnt + 32'd1;
      if ((state == eResp) && bus.yumi_i[tag] && (ops_cnt != '1)) ops_cnt <= ops_cnt + 32'd1;
    end
  end

  assign busy_cycles_o = busy_cnt;
  assign ops_done_o    = ops_cnt;
`endif
endmodule

// File: tb/tb_bsg_idiv_arb.sv
// tb/tb_bsg_idiv_arb.sv - scoreboard bench for bsg_idiv_arb with a behavioural divider
module tb_bsg_idiv_arb;
  localparam int els_p   = 4;
  localparam int width_p = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_idiv_arb_if #(.els_p(els_p), .width_p(width_p)) bus ();

`ifdef BSG_IDIV_ARB_PERF_EN
  logic [31:0] busy_cycles;
  logic [31:0] ops_done;
`endif

  bsg_idiv_arb #(.els_p(els_p), .width_p(width_p)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
`ifdef BSG_IDIV_ARB_PERF_EN
    .busy_cycles_o(busy_cycles),
    .ops_done_o   (ops_done),
`endif
    .bus          (bus)
  );

  typedef struct {
    int          tag;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
  } op_t;

  int checks = 0;
  int failures = 0;

  op_t sb[$];
  int  grant_log[$];
  int  m_ptr = 0;
  int  m_phase = 0;        // 0 idle, 1 issuing, 2 divider busy, 3 result held
  int  issue_cycles = 0;
  int  last_issue_cycles = 0;
  int  pops = 0;
  int  pops_since_reset = 0;
  int  busy_model = 0;
  logic [3:0]  last_vo = '0;
  logic [31:0] last_q = '0, last_r = '0;

  logic [3:0] acc_flag = '0;
  logic dfire = 1'b0, rfire = 1'b0;

  logic [3:0]  req_pend = '0;
  logic [31:0] req_dvd[els_p];
  logic [31:0] req_dvs[els_p];
  logic        req_sgn[els_p];
  logic [3:0]  auto_refill = '0;
  bit rand_mode = 1'b0;
  int stall_cfg = 0;
  int lat_max = 2;
  int yumi_delay = 0;
  int resp_age = 0;

  int dv_state = 0, dv_cnt = 0, stall_ctr = 0;
  logic [31:0] dv_a, dv_b;
  logic        dv_s;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic new_req(input int k);
    logic [31:0] a, b;
    logic s;
    s = 1'($urandom_range(0, 1));
    a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
    b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
    if (b == 32'd0) b = 32'd1;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
    req_dvd[k] = a;
    req_dvs[k] = b;
    req_sgn[k] = s;
    req_pend[k] = 1'b1;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_dvd[k] = a;
    req_dvs[k] = b;
    req_sgn[k] = s;
    req_pend[k] = 1'b1;
  endtask

  task automatic chk_zero_outputs(input string tag_s);
    chk({tag_s, "_ready"}, 32'(bus.ready_and_o), 32'd0);
    chk({tag_s, "_v_o"}, 32'(bus.v_o), 32'd0);
    chk({tag_s, "_quot"}, bus.quotient_o, 32'd0);
    chk({tag_s, "_rem"}, bus.remainder_o, 32'd0);
    chk({tag_s, "_div_v"}, 32'(bus.div_v_o), 32'd0);
    chk({tag_s, "_div_dvd"}, bus.div_dividend_o, 32'd0);
    chk({tag_s, "_div_dvs"}, bus.div_divisor_o, 32'd0);
    chk({tag_s, "_div_sgn"}, 32'(bus.div_signed_o), 32'd0);
    chk({tag_s, "_div_yumi"}, 32'(bus.div_yumi_o), 32'd0);
`ifdef BSG_IDIV_ARB_PERF_EN
    chk({tag_s, "_busy_cnt"}, busy_cycles, 32'd0);
    chk({tag_s, "_ops_cnt"}, ops_done, 32'd0);
`endif
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(m_phase == 0 && req_pend == 4'd0 && sb.size() == 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_idle timeout actual=%0d cycles required<%0d", n, budget);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  // reset is released just after a posedge so the monitor samples the first
  // post-reset cycle before any accept can happen
  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("reset_pulse");
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk); #1;
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  logic [3:0] exp_g;
  op_t        mon_op;
  always @(negedge clk) begin
    acc_flag = '0;
    dfire = 1'b0;
    rfire = 1'b0;
    if (!reset_n) begin
      sb.delete();
      m_ptr = 0;
      m_phase = 0;
      pops_since_reset = 0;
      busy_model = 0;
    end else begin
      if (m_phase != 0) busy_model++;
      if (m_phase == 0) begin
        exp_g = '0;
        for (int i = 0; i < els_p; i++)
          if (exp_g == 4'd0 && bus.v_i[(m_ptr + i) % els_p]) exp_g[(m_ptr + i) % els_p] = 1'b1;
        chk("grant", 32'(bus.ready_and_o), 32'(exp_g));
        chk("idle_v_o", 32'(bus.v_o), 32'd0);
        chk("idle_div_v", 32'(bus.div_v_o), 32'd0);
        for (int k = 0; k < els_p; k++) begin
          if (bus.v_i[k] && bus.ready_and_o[k] && acc_flag == 4'd0) begin
            mon_op.tag = k;
            mon_op.dvd = bus.dividend_i[k*width_p +: width_p];
            mon_op.dvs = bus.divisor_i[k*width_p +: width_p];
            mon_op.sgn = bus.signed_div_i[k];
            ref_div(mon_op.dvd, mon_op.dvs, mon_op.sgn, mon_op.q, mon_op.r);
            sb.push_back(mon_op);
            grant_log.push_back(k);
            acc_flag[k] = 1'b1;
            m_phase = 1;
            issue_cycles = 0;
          end
        end
      end else begin
        chk("busy_no_grant", 32'(bus.ready_and_o), 32'd0);
        case (m_phase)
          1: begin
            issue_cycles++;
            chk("issue_div_v", 32'(bus.div_v_o), 32'd1);
            chk("issue_v_o", 32'(bus.v_o), 32'd0);
            chk("issue_dividend", bus.div_dividend_o, sb[0].dvd);
            chk("issue_divisor", bus.div_divisor_o, sb[0].dvs);
            chk("issue_signed", 32'(bus.div_signed_o), 32'(sb[0].sgn));
            if (bus.div_ready_and_i) begin
              dfire = 1'b1;
              m_phase = 2;
              last_issue_cycles = issue_cycles;
            end
          end
          2: begin
            chk("wait_div_v", 32'(bus.div_v_o), 32'd0);
            chk("wait_v_o", 32'(bus.v_o), 32'd0);
            chk("wait_div_yumi", 32'(bus.div_yumi_o), 32'(bus.div_v_i));
            if (bus.div_v_i) begin
              rfire = 1'b1;
              m_phase = 3;
            end
          end
          default: begin
            chk("resp_v_o", 32'(bus.v_o), 32'(4'b0001 << sb[0].tag));
            chk("resp_quot", bus.quotient_o, sb[0].q);
            chk("resp_rem", bus.remainder_o, sb[0].r);
            chk("resp_div_v", 32'(bus.div_v_o), 32'd0);
            if (bus.yumi_i[sb[0].tag]) begin
              last_vo = bus.v_o;
              last_q = bus.quotient_o;
              last_r = bus.remainder_o;
              m_ptr = (sb[0].tag + 1) % els_p;
              void'(sb.pop_front());
              pops++;
              pops_since_reset++;
              m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Driver: clients plus a behavioural iterative divider, updated just after posedge.
  logic [31:0] dq, dr;
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < els_p; k++) begin
      if (acc_flag[k]) req_pend[k] = 1'b0;
      if (!req_pend[k] && (auto_refill[k] || (rand_mode && $urandom_range(0, 3) == 0))) new_req(k);
      else if (req_pend[k] && rand_mode && !acc_flag[k] && $urandom_range(0, 15) == 0) req_pend[k] = 1'b0;
      bus.dividend_i[k*width_p +: width_p] = req_pend[k] ? req_dvd[k] : $urandom;
      bus.divisor_i[k*width_p +: width_p]  = req_pend[k] ? req_dvs[k] : $urandom;
      bus.signed_div_i[k] = req_pend[k] ? req_sgn[k] : 1'($urandom_range(0, 1));
    end
    bus.v_i = req_pend;
    if (!reset_n) begin
      dv_state = 0;
      stall_ctr = 0;
      resp_age = 0;
      bus.div_v_i = 1'b0;
      bus.div_ready_and_i = 1'b0;
      bus.div_quotient_i = '0;
      bus.div_remainder_i = '0;
      bus.yumi_i = '0;
    end else begin
      if (rfire) begin
        bus.div_v_i = 1'b0;
        dv_state = 0;
      end
      if (dfire) begin
        dv_a = bus.div_dividend_o;
        dv_b = bus.div_divisor_o;
        dv_s = bus.div_signed_o;
        dv_cnt = $urandom_range(1, lat_max);
        dv_state = 1;
        stall_ctr = 0;
        if (rand_mode) stall_cfg = $urandom_range(0, 3);
      end else if (dv_state == 1) begin
        dv_cnt--;
      end
      if (dv_state == 1 && dv_cnt == 0) begin
        ref_div(dv_a, dv_b, dv_s, dq, dr);
        bus.div_quotient_i = dq;
        bus.div_remainder_i = dr;
        bus.div_v_i = 1'b1;
        dv_state = 2;
      end
      if (dv_state == 0) begin
        bus.div_ready_and_i = (stall_ctr >= stall_cfg);
        if (bus.div_v_o && !bus.div_ready_and_i) stall_ctr++;
      end else begin
        bus.div_ready_and_i = 1'b0;
      end
      if (bus.v_o != 4'd0) resp_age++;
      else resp_age = 0;
      if (rand_mode && resp_age == 1) yumi_delay = $urandom_range(0, 3);
      bus.yumi_i = (resp_age > yumi_delay) ? bus.v_o : 4'd0;
      if (rand_mode) bus.yumi_i = bus.yumi_i | (4'($urandom) & ~bus.v_o);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    req_pend = 4'hF;
    for (int k = 0; k < els_p; k++) begin
      req_dvd[k] = 32'd1;
      req_dvs[k] = 32'd1;
      req_sgn[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk_zero_outputs("reset");
    req_pend = 4'h0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk); #1;

    // client 0 only, signed -7 / 2
    set_req(0, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle(200);
    chk("t1_v_o", 32'(last_vo), 32'h1);
    chk("t1_quot", last_q, 32'hFFFF_FFFD);
    chk("t1_rem", last_r, 32'hFFFF_FFFF);

    // client 2 only, unsigned 100 / 7, then search resumes at client 3
    set_req(2, 32'd100, 32'd7, 1'b0);
    wait_idle(200);
    chk("t2_v_o", 32'(last_vo), 32'h4);
    chk("t2_quot", last_q, 32'd14);
    chk("t2_rem", last_r, 32'd2);
    grant_log.delete();
    set_req(0, 32'd9, 32'd3, 1'b0);
    set_req(3, 32'd50, 32'd6, 1'b0);
    wait_idle(300);
    chk("t2_next_grant", 32'(grant_log[0]), 32'd3);
    chk("t2_then_grant", 32'(grant_log[1]), 32'd0);

    // all four held from reset, immediate consume
    do_reset();
    grant_log.delete();
    auto_refill = 4'hF;
    n = 0;
    while (grant_log.size() < 6 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    auto_refill = 4'h0;
    wait_idle(500);
    for (int i = 0; i < 6; i++) chk("t3_order", 32'(grant_log[i]), 32'(i % 4));

    // client 1 result held 5 cycles while others request
    yumi_delay = 5;
    set_req(1, 32'd1000, 32'd33, 1'b0);
    n = 0;
    while (m_phase == 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    set_req(0, $urandom, 32'd5, 1'b1);
    set_req(2, $urandom, 32'd9, 1'b0);
    set_req(3, $urandom, 32'd11, 1'b1);
    wait_idle(500);
    yumi_delay = 0;

    // divider refuses for 3 cycles
    stall_cfg = 3;
    set_req(2, 32'hFFFF_FF00, 32'd16, 1'b1);
    wait_idle(200);
    chk("t5_issue_cycle", 32'(last_issue_cycles), 32'd4);
    chk("t5_quot", last_q, 32'hFFFF_FFF0);
    stall_cfg = 0;

    // randomized traffic
    lat_max = 6;
    p0 = pops;
    rand_mode = 1'b1;
    n = 0;
    while (pops < p0 + 150 && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (pops < p0 + 150) begin
      failures++;
      $display("FAIL random_progress actual=%0d required=%0d", pops - p0, 150);
    end
    rand_mode = 1'b0;
    stall_cfg = 0;
    yumi_delay = 0;
    wait_idle(2000);

`ifdef BSG_IDIV_ARB_PERF_EN
    chk("perf_ops", ops_done, 32'(pops_since_reset));
    chk("perf_busy", busy_cycles, 32'(busy_model));
`endif

    // reset during divider wait
    auto_refill = 4'hF;
    n = 0;
    while (m_phase != 2 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t7_reached_wait", 32'(m_phase), 32'd2);
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    grant_log.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    n = 0;
    while (grant_log.size() == 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t7_grant_after_reset", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd0);
    auto_refill = 4'h0;
    wait_idle(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bsg_idiv_arb.md
Name: bsg_idiv_arb

Overview:
- Shares one iterative integer divider (bsg_idiv_iterative-style interface) among els_p requesters.
- Round-robin arbitration; winner's operands are registered, then issued to the divider. The result is routed back to the owning client only.
- One operation is in flight at a time. The divider is the shared resource; the block is the only master of its interface.

Parameters:
- els_p, 4, number of requesting clients (2..16)
- width_p, 32, operand/result width; must match the divider's width_p
- lg_els_lp, $clog2(els_p), local; width of tag and round-robin pointer

Ports:
- clk_i  in  1  clock; all logic on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- v_i  in  els_p  per-client request valid
- dividend_i  in  els_p*width_p  client k operand at [k*width_p +: width_p]
- divisor_i  in  els_p*width_p  same packing as dividend_i
- signed_div_i  in  els_p  per-client signed select
- ready_and_o  out  els_p  one-hot grant; request k accepted on v_i[k] & ready_and_o[k]
- v_o  out  els_p  one-hot result valid, only to the owning client
- quotient_o  out  width_p  result quotient, shared bus, valid where v_o[k]
- remainder_o  out  width_p  result remainder, shared bus
- yumi_i  in  els_p  per-client result consume
- div_v_o  out  1  request to divider
- div_dividend_o  out  width_p  registered operand
- div_divisor_o  out  width_p  registered operand
- div_signed_o  out  1  registered signed select
- div_ready_and_i  in  1  divider ready
- div_v_i  in  1  divider result valid
- div_quotient_i  in  width_p  divider quotient
- div_remainder_i  in  width_p  divider remainder
- div_yumi_o  out  1  divider result consume

Behaviour:
- FSM states: eIdle, eIssue, eWait, eResp. On reset_n_i low (async):
  - state=eIdle, rr_ptr=0, tag=0.
  - Operand/result regs cleared to 0.
  - All outputs 0.
- eIdle:
  - If |v_i, ready_and_o is one-hot to the first set v_i at or after rr_ptr, wrapping modulo els_p.
  - ready_and_o may depend combinationally on v_i.
  - On accept: latch dividend, divisor, signed and tag=k; go to eIssue. Otherwise ready_and_o=0 and stay.
- eIssue:
  - div_v_o=1 with the registered operands.
  - On div_ready_and_i=1: go to eWait. Otherwise hold div_v_o and the operands stable.
- eWait:
  - div_yumi_o=div_v_i.
  - On div_v_i=1: latch quotient/remainder; go to eResp.
- eResp:
  - v_o[tag]=1 and all other v_o bits 0; quotient_o/remainder_o come from registers.
  - On yumi_i[tag]: rr_ptr=(tag+1) mod els_p; go to eIdle.
  - yumi_i bits other than tag are ignored.
  - No grant is issued while in eResp.
- ready_and_o=0 in every state except eIdle. Outputs come only from registers, except ready_and_o and div_yumi_o.
- Latency from accept to v_o: 1 (eIssue) + divider handshake/compute latency + 1 (result latch).
- Results pass through unmodified: divide-by-zero and signed-overflow values are whatever the divider returns.
- Fairness: a client holding v_i waits at most els_p-1 other operations.
- A client dropping v_i before grant is legal; requests are not retained.
- Reset asserted mid-operation: the in-flight op is discarded and no v_o is produced. The divider must share the same reset.
- Widths: no arithmetic on operands; rr_ptr/tag wrap from els_p-1 to 0. Non-power-of-two els_p must wrap correctly.

Optional Feature:
- BSG_IDIV_ARB_PERF_EN
- Defined:
  - Adds output busy_cycles_o [31:0], counting cycles with state != eIdle.
  - Adds output ops_done_o [31:0], incremented on each yumi_i[tag] in eResp.
  - Both counters saturate at 2^32-1 and reset to 0.
- Undefined: neither port nor its counter exists.

Test Plan:
- Client 0 only, signed=1, dividend=0xFFFFFFF9 (-7), divisor=2 -> v_o=4'b0001, quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Client 2 only, signed=0, dividend=100, divisor=7 -> v_o=4'b0100, quotient=14, remainder=2; next idle grant search starts at client 3.
- All four v_i held continuously after reset, yumi_i immediate -> grant order 0,1,2,3,0,1; each result returned to the matching v_o bit.
- Client 1 result with yumi_i held low 5 cycles -> v_o[1] and quotient/remainder stable for 5 cycles; ready_and_o=0 and div_v_o=0 throughout.
- Divider model holds div_ready_and_i=0 for 3 cycles in eIssue -> div_v_o and operands stable; issue occurs on cycle 4.
- reset_n_i pulsed low during eWait -> all outputs 0 immediately; no v_o for the dropped op; next grant goes to client 0. With BSG_IDIV_ARB_PERF_EN, both counters read 0.
